// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, handshakes with imem and feeds the IF/ID register.
// A one-entry skid buffer catches a fetch that lands during a stall. IF_PERF_CNT_EN adds perf counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_ins,
  output logic        if_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic {FETCH, BUFFERED} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } fetch_t;

  state_t      state, state_n;
  // PC is kept as a word address so alignment and the 2^32 wrap come for free
  logic [29:0] pc_w, pc_w_n;
  logic [31:0] cur_pc;
  fetch_t      out_q, out_n;
  fetch_t      buf_q, buf_n;
  logic        vld_q, vld_n;
  logic        ack_ok;
  logic        unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign cur_pc    = {pc_w, 2'b00};
  assign imem_req  = (state == FETCH) && !rst;
  assign imem_addr = cur_pc;
  assign ack_ok    = imem_req && imem_ack;

  assign if_pc    = out_q.pc;
  assign if_ins   = out_q.ins;
  assign if_valid = vld_q;

  always_comb begin
    state_n = state;
    pc_w_n  = pc_w;
    out_n   = out_q;
    buf_n   = buf_q;
    vld_n   = vld_q;
    if (redirect) begin
      // Redirect wins over stall: the bubble is written even while stalled
      pc_w_n    = redirect_pc[31:2];
      out_n.ins = '0;
      vld_n     = 1'b0;
      state_n   = FETCH;
    end else begin
      unique case (state)
        FETCH: begin
          if (!stall) begin
            if (ack_ok) begin
              out_n  = '{pc: cur_pc, ins: imem_rdata};
              vld_n  = 1'b1;
              pc_w_n = pc_w + 30'd1;
            end else begin
              out_n.ins = '0;
              vld_n     = 1'b0;
            end
          end else if (ack_ok) begin
            buf_n   = '{pc: cur_pc, ins: imem_rdata};
            pc_w_n  = pc_w + 30'd1;
            state_n = BUFFERED;
          end
        end
        BUFFERED: begin
          if (!stall) begin
            out_n   = buf_q;
            vld_n   = 1'b1;
            state_n = FETCH;
          end
        end
        default: state_n = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      pc_w  <= RESET_PC[31:2];
      out_q <= '0;
      buf_q <= '0;
      vld_q <= 1'b0;
    end else begin
      state <= state_n;
      pc_w  <= pc_w_n;
      out_q <= out_n;
      buf_q <= buf_n;
      vld_q <= vld_n;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (ack_ok && !redirect) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (stall)               perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: expected fetches are queued as stimulus is driven
// and popped when the stage presents a new valid instruction.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_ins;
  logic        if_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] ins_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  assign imem_rdata = ins_of(imem_addr);

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_pc      (if_pc),
    .if_ins     (if_ins),
    .if_valid   (if_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic expect_fetch(input logic [31:0] pc);
    exp_t e;
    e.pc  = pc;
    e.ins = ins_of(pc);
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs, clock it, then check what the stage presented.
  task automatic cyc(input logic s, input logic a, input logic r, input logic [31:0] rp);
    logic [31:0] p_pc, p_ins;
    logic        p_vld;
    exp_t        e;
    stall = s; imem_ack = a; redirect = r; redirect_pc = rp;
    p_pc = if_pc; p_ins = if_ins; p_vld = if_valid;
    @(posedge clk); #1;
    if (r) begin
      chk("redir_valid", 32'(if_valid), 32'd0);
      chk("redir_ins", if_ins, 32'd0);
    end else if (s) begin
      chk("hold_pc", if_pc, p_pc);
      chk("hold_ins", if_ins, p_ins);
      chk("hold_valid", 32'(if_valid), 32'(p_vld));
    end else if (if_valid) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("fetch_pc", if_pc, e.pc);
        chk("fetch_ins", if_ins, e.ins);
      end
    end else begin
      chk("bubble_ins", if_ins, 32'd0);
    end
  endtask

  initial begin
    #12;
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_ins", if_ins, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
`ifdef IF_PERF_CNT_EN
    chk("rst_perf_fetch", perf_fetch_cnt, 32'd0);
    chk("rst_perf_stall", perf_stall_cnt, 32'd0);
`endif
    rst = 1'b0;
    #1;
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'd0);

    // zero-wait streaming
    expect_fetch(32'h0); cyc(0, 1, 0, 0);
    expect_fetch(32'h4); cyc(0, 1, 0, 0);
    chk("addr_8", imem_addr, 32'h8);

    // three wait states at pc=8
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      chk("wait_valid", 32'(if_valid), 32'd0);
      chk("wait_addr", imem_addr, 32'h8);
    end
    expect_fetch(32'h8);  cyc(0, 1, 0, 0);
    expect_fetch(32'hC);  cyc(0, 1, 0, 0);

    // stall with ack in its first cycle -> skid buffer
    cyc(1, 1, 0, 0);
    chk("buf_req", 32'(imem_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0);
      chk("buf_req_hold", 32'(imem_req), 32'd0);
    end
    expect_fetch(32'h10); cyc(0, 0, 0, 0);
    chk("post_buf_addr", imem_addr, 32'h14);
    chk("post_buf_req", 32'(imem_req), 32'd1);
    expect_fetch(32'h14); cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    chk("stall_noack_addr", imem_addr, 32'h18);

    // redirect beats stall and a same-cycle ack
    cyc(1, 1, 1, 32'h0000_0103);
    chk("redir_addr", imem_addr, 32'h100);
    expect_fetch(32'h100); cyc(0, 1, 0, 0);

    // redirect to top of memory, pc wraps
    cyc(0, 1, 1, 32'hFFFF_FFFC);
    chk("redir_top_addr", imem_addr, 32'hFFFF_FFFC);
    expect_fetch(32'hFFFF_FFFC); cyc(0, 1, 0, 0);
    chk("wrap_addr", imem_addr, 32'h0);
    expect_fetch(32'h0); cyc(0, 1, 0, 0);

    // async reset while BUFFERED
    cyc(1, 1, 0, 0);
    chk("pre_rst_req", 32'(imem_req), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(if_valid), 32'd0);
    chk("arst_ins", if_ins, 32'd0);
    chk("arst_pc", if_pc, 32'd0);
    chk("arst_req", 32'(imem_req), 32'd0);
`ifdef IF_PERF_CNT_EN
    chk("arst_perf_fetch", perf_fetch_cnt, 32'd0);
    chk("arst_perf_stall", perf_stall_cnt, 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0; stall = 1'b0; imem_ack = 1'b0;
    #1;
    chk("restart_req", 32'(imem_req), 32'd1);
    chk("restart_addr", imem_addr, 32'h0);
    expect_fetch(32'h0); cyc(0, 1, 0, 0);
`ifdef IF_PERF_CNT_EN
    chk("perf_fetch_1", perf_fetch_cnt, 32'd1);
    chk("perf_stall_0", perf_stall_cnt, 32'd0);
`endif
    cyc(1, 0, 0, 0);
`ifdef IF_PERF_CNT_EN
    chk("perf_stall_1", perf_stall_cnt, 32'd1);
    chk("perf_fetch_hold", perf_fetch_cnt, 32'd1);
`endif
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
